// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NUM_DIGITS common-anode
// 7-segment digits sharing a single hex decoder.
//
// Every digit owns a slot of REFRESH_DIV cycles: BLANK_CYCLES with all anodes
// off, then the rest of the slot with that digit's anode low. The nibble for
// the slot is placed on dec_d at the start of the slot, so it is stable before
// the anode turns on. The displayed word is double-buffered and only changes
// at frame boundaries.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   value      word to display, nibble i = value[4i+3:4i]
//   load       1-cycle strobe, captures value into the pending buffer
//   digit_en   per-digit enable, 0 keeps that anode off (sampled live)
//   dec_d      nibble to the shared segment decoder (registered)
//   an         active-low anode drives (registered)
//   cur_digit  index of the digit slot in progress (registered)
//   frame_tick 1-cycle pulse when the scan wraps back to digit 0 (registered)
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          LZ_SUPPRESS  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              dec_d,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [2:0]              cur_digit,
    output logic                    frame_tick
);

    localparam int unsigned CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned WORD_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW   = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [2:0]          cur_n;
    logic [3:0]          dec_n;
    logic [NUM_DIGITS-1:0] an_n;
    logic                tick_n;
    logic [WORD_W-1:0]   active, active_n;
    logic [WORD_W-1:0]   pending, pending_n;
    logic                pending_valid, pending_valid_n;

    logic                slot_wrap;
    logic                commit;
    logic                nz_run;
    logic [NUM_DIGITS-1:0] keep_digit;
    logic [3:0]          cur_nib;

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_BLANK;
            cnt           <= '0;
            cur_digit     <= '0;
            dec_d         <= '0;
            an            <= '1;
            frame_tick    <= 1'b0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            cur_digit     <= cur_n;
            dec_d         <= dec_n;
            an            <= an_n;
            frame_tick    <= tick_n;
            active        <= active_n;
            pending       <= pending_n;
            pending_valid <= pending_valid_n;
        end
    end

    // Next-state, buffering and output decode. Outputs are computed from the
    // next-cycle slot position so the registered values line up with cnt.
    always_comb begin
        state_n         = state;
        active_n        = active;
        pending_n       = pending;
        pending_valid_n = pending_valid;
        an_n            = '1;
        cur_nib         = '0;
        keep_digit      = '0;
        nz_run          = 1'b0;

        slot_wrap = (cnt == CNT_LAST);
        commit    = slot_wrap && (cur_digit == DIGIT_LAST);
        cnt_n     = slot_wrap ? '0 : cnt + CNT_W'(1);
        cur_n     = slot_wrap ? (commit ? 3'd0 : cur_digit + 3'd1) : cur_digit;
        tick_n    = commit;

        case (state)
            ST_BLANK: if (cnt_n == CNT_SHOW) state_n = ST_SHOW;
            ST_SHOW:  if (slot_wrap)         state_n = ST_BLANK;
            default:                         state_n = ST_BLANK;
        endcase

        // A load on the commit cycle goes straight to the active buffer.
        if (commit) begin
            if (load) begin
                active_n = value;
            end else if (pending_valid) begin
                active_n = pending;
            end
            pending_valid_n = 1'b0;
            if (load) pending_n = value;
        end else if (load) begin
            pending_n       = value;
            pending_valid_n = 1'b1;
        end

        // Scan from the top nibble down: a digit is kept once any nibble at or
        // above it is non-zero. Digit 0 is always kept.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_run        = nz_run | (|active_n[4*i +: 4]);
            keep_digit[i] = nz_run || (i == 0) || !LZ_SUPPRESS;
        end

        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cur_n == 3'(i)) begin
                cur_nib = active_n[4*i +: 4];
                if (state_n == ST_SHOW && digit_en[i] && keep_digit[i]) begin
                    an_n[i] = 1'b0;
                end
            end
        end

        // The decoder input only moves on the first blank cycle of a slot.
        dec_n = (cnt_n == '0) ? cur_nib : dec_d;
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl. Two instances (leading-zero suppression off and
// on) share one stimulus stream. A reference model based on elapsed cycle
// count predicts each cycle's outputs into a queue; a monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FR = N * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;

    logic [3:0] dec0, dec1, an0, an1;
    logic [2:0] cur0, cur1;
    logic       tick0, tick1;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(1'b0)) u_nolz (
        .clk(clk), .rst(rst), .value(value), .load(load), .digit_en(digit_en),
        .dec_d(dec0), .an(an0), .cur_digit(cur0), .frame_tick(tick0)
    );

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_SUPPRESS(1'b1)) u_lz (
        .clk(clk), .rst(rst), .value(value), .load(load), .digit_en(digit_en),
        .dec_d(dec1), .an(an1), .cur_digit(cur1), .frame_tick(tick1)
    );

    typedef struct packed {
        logic [3:0] dec;
        logic [3:0] an_nolz;
        logic [3:0] an_lz;
        logic [2:0] cur;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time since reset, plus active/pending words.
    int unsigned t = 0;
    logic [15:0] m_active  = '0;
    logic [15:0] m_pending = '0;
    bit          m_pv      = 1'b0;

    logic [15:0] cur_val = '0;
    logic [3:0]  cur_en  = 4'hF;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, req, $time);
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected outputs.
    task automatic step(input bit r, input bit ld, input logic [15:0] v, input logic [3:0] en);
        exp_t e;
        int   pos, dg;
        @(negedge clk);
        rst = r; load = ld; value = v; digit_en = en;
        if (r) begin
            t = 0; m_active = '0; m_pending = '0; m_pv = 1'b0;
        end else begin
            if (((t + 1) % FR) == 0) begin
                if (ld) m_active = v;
                else if (m_pv) m_active = m_pending;
                m_pv = 1'b0;
            end else if (ld) begin
                m_pending = v;
                m_pv = 1'b1;
            end
            t++;
        end
        pos = int'(t % R);
        dg  = int'((t / R) % N);
        e.cur  = 3'(dg);
        e.dec  = 4'(m_active >> (4 * dg));
        e.tick = (t != 0) && ((t % FR) == 0);
        e.an_nolz = 4'hF;
        e.an_lz   = 4'hF;
        if (pos >= B && ((en >> dg) & 4'd1) != 0) begin
            e.an_nolz = ~(4'd1 << dg);
            if (dg == 0 || (m_active >> (4 * dg)) != 0) e.an_lz = e.an_nolz;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, cur_val, cur_en);
    endtask

    task automatic do_load(input logic [15:0] v);
        cur_val = v;
        step(1'b0, 1'b1, v, cur_en);
    endtask

    // Idle until the next step lands on frame position pos.
    task automatic wait_pos(input int pos);
        for (int k = 0; k < FR; k++) begin
            if (((t + 1) % FR) == pos) break;
            idle(1);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dec_d_nolz",     int'(dec0),  int'(e.dec));
                chk("dec_d_lz",       int'(dec1),  int'(e.dec));
                chk("an_nolz",        int'(an0),   int'(e.an_nolz));
                chk("an_lz",          int'(an1),   int'(e.an_lz));
                chk("cur_digit_nolz", int'(cur0),  int'(e.cur));
                chk("cur_digit_lz",   int'(cur1),  int'(e.cur));
                chk("frame_tick_nolz", int'(tick0), int'(e.tick));
                chk("frame_tick_lz",  int'(tick1), int'(e.tick));
                chk("an_onehot_nolz", int'($countones(~an0) <= 1), 1);
                chk("an_onehot_lz",   int'($countones(~an1) <= 1), 1);
            end
        end
    end

    initial begin
        int r;
        // Reset and basic scan of 0x1234.
        step(1'b1, 1'b0, '0, 4'hF);
        step(1'b1, 1'b0, '0, 4'hF);
        do_load(16'h1234);
        idle(3 * FR);

        // Reload during digit 1, then two loads in one frame.
        wait_pos(11);
        do_load(16'hABCD);
        idle(2 * FR);
        wait_pos(5);
        do_load(16'h1111);
        idle(9);
        do_load(16'h2222);
        idle(2 * FR);

        // Leading-zero cases.
        do_load(16'h0050);
        idle(2 * FR);
        do_load(16'h0000);
        idle(2 * FR);

        // Partial digit enables.
        cur_en = 4'b1010;
        do_load(16'h1234);
        idle(2 * FR);
        cur_en = 4'hF;

        // Reset mid-SHOW of digit 2.
        wait_pos(20);
        idle(1);
        step(1'b1, 1'b0, cur_val, cur_en);
        idle(FR + 4);

        // Load on the commit cycle bypasses into the active buffer.
        do_load(16'h1234);
        idle(FR);
        wait_pos(0);
        do_load(16'h9876);
        idle(2 * FR);

        // Randomised traffic.
        for (int k = 0; k < 800; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                step(1'b1, 1'b0, cur_val, cur_en);
            end else if (r < 12) begin
                case ($urandom_range(0, 2))
                    0:       do_load(16'($urandom));
                    1:       do_load(16'($urandom) & 16'h00FF);
                    default: do_load(16'h0000);
                endcase
            end else begin
                if (r > 95) cur_en = 4'($urandom);
                idle(1);
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
